epu_layer_sched: RTL and testbench
==================================

Name: epu_layer_sched

Overview:
- Layer-level scheduler for the EPU. Walks a list of per-layer descriptors held in a descriptor SRAM.
- For each layer it starts exactly one compute engine (1x1 conv, 3x3 conv, pool, etc.), hands it that layer's w8 codebook word, and waits for its finish pulse.
- Sits between the host CSR block and the engine start/finish pins. Raises done when the whole network pass completes, or err on a fault.

Parameters:
- NUM_ENG, 4, number of engines (one-hot start / finish vectors).
- LAYER_W, 6, width of the layer count and layer index.
- DESC_AW, 8, descriptor SRAM address width.
- TIMEOUT_W, 20, width of the per-layer watchdog counter; timeout fires at all-ones.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- cfg_start  in  1  one-cycle pulse: begin a pass
- cfg_num_layer  in  LAYER_W  number of layers; sampled on cfg_start
- cfg_desc_base  in  DESC_AW  first descriptor word address; sampled on cfg_start
- desc_cs  out  1  descriptor SRAM chip select (read only)
- desc_addr  out  DESC_AW  descriptor SRAM address
- desc_rdata  in  32  descriptor read data, valid 1 cycle after desc_cs
- eng_start  out  NUM_ENG  one-hot, one-cycle start pulse
- eng_w8  out  32  codebook word for the started engine
- eng_finish  in  NUM_ENG  per-engine finish pulses
- busy  out  1  high from the cycle after cfg_start until DONE/ERR exits
- done  out  1  one-cycle pulse on pass completion
- err  out  1  sticky error flag
- layer_idx  out  LAYER_W  index of the current layer

Behaviour:
- Reset values:
  - Outputs: desc_cs=0, desc_addr=0, eng_start=0, eng_w8=0, busy=0, done=0, err=0, layer_idx=0.
  - Internal: FSM=IDLE, watchdog=0.
- Descriptor format, 2 words per layer at cfg_desc_base + 2*layer_idx:
  - word0[1:0] = engine id; word0[31:2] is ignored.
  - word1 = w8 codebook.
- FSM states: IDLE, RD_W0, RD_W1, CAP, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - cfg_start with cfg_num_layer≠0 -> latch cfg fields, clear err, layer_idx=0, go to RD_W0.
  - cfg_start with cfg_num_layer=0 -> DONE.
- RD_W0: desc_cs=1, desc_addr=base+2*idx -> RD_W1.
- RD_W1: desc_cs=1, desc_addr=base+2*idx+1; capture word0 engine id from desc_rdata -> CAP.
- CAP: desc_cs=0; capture word1 into eng_w8.
  - Engine id ≥ NUM_ENG -> ERR.
  - Otherwise -> ISSUE.
- ISSUE: eng_start[sel]=1 for exactly this cycle; clear watchdog -> WAIT.
- WAIT: watchdog increments each cycle.
  - eng_finish[sel]=1 and idx = num_layer-1 -> DONE.
  - eng_finish[sel]=1 otherwise -> layer_idx+1, then RD_W0.
  - Any eng_finish[j] with j≠sel -> ERR. This takes priority over the selected finish in the same cycle.
  - Watchdog reaches all-ones -> ERR.
- DONE: done=1 for one cycle -> IDLE.
- ERR: err set (sticky until the next accepted cfg_start) -> IDLE. No done pulse.
- Timing:
  - Overhead is 4 cycles per layer from the finish pulse (or cfg_start) to the next eng_start.
  - For the first layer, eng_start is asserted 4 cycles after cfg_start.
- eng_w8 is held stable from CAP until the next CAP. Engines latch it on start.
- cfg_start while busy is ignored; latched config is unchanged.
- eng_finish outside WAIT is ignored.
- Address arithmetic wraps modulo 2^DESC_AW.
- Reset deassertion mid-pass: all state is cleared; engines are not notified. The system resets engines together with this block.

Decomposition:
- Package epu_sched_pkg holds:
  - sched_state_e enum.
  - Descriptor field constants: ENG_ID_LSB=0, ENG_ID_W=2, DESC_WORDS=2.
  - Engine id constants: ENG_CONV1X1=0, ENG_CONV3X3=1, ENG_POOL=2, ENG_FC=3.
- Single module; no sub-module needed. The watchdog stays inline.

Test Plan:
- 3 layers, descriptors {id0,w8=0x01020304}, {id1,0xA0B0C0D0}, {id0,0xFFFFFFFF}, each engine finishing 10 cycles after start -> eng_start = 0001, 0010, 0001 in order; eng_w8 matches at each start; each start comes 4 cycles after the previous finish; one done pulse; err=0; layer_idx ends at 2.
- cfg_num_layer=0 -> done pulse 2 cycles after cfg_start; eng_start never asserted; desc_cs never asserted.
- Descriptor word0=0x6, NUM_ENG=2 -> ERR, err=1, no eng_start, no done; a following good cfg_start clears err.
- During WAIT for engine 1, assert eng_finish=0b0101 -> err=1, FSM returns to IDLE, busy drops.
- TIMEOUT_W=4, engine never finishes -> err after 15 WAIT cycles; a second cfg_start issued while busy is ignored (no extra reads).
- Assert rstn=0 for one cycle during WAIT of layer 1 -> all outputs return to reset values on the next edge; a subsequent pass restarts at layer 0.

Source files
------------

// File: rtl/epu_layer_sched_pkg.sv
// Shared types and descriptor field layout for the EPU layer scheduler.
package epu_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_W0,
        S_RD_W1,
        S_CAP,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } sched_state_e;

    localparam int unsigned ENG_ID_LSB = 0;
    localparam int unsigned ENG_ID_W   = 2;
    localparam int unsigned DESC_WORDS = 2;

    localparam logic [ENG_ID_W-1:0] ENG_CONV1X1 = 2'd0;
    localparam logic [ENG_ID_W-1:0] ENG_CONV3X3 = 2'd1;
    localparam logic [ENG_ID_W-1:0] ENG_POOL    = 2'd2;
    localparam logic [ENG_ID_W-1:0] ENG_FC      = 2'd3;

endpackage

// File: rtl/epu_layer_sched.sv
// Layer scheduler: fetches two-word descriptors per layer, starts one engine,
// waits for its finish pulse under a watchdog, and reports done or err.
module epu_layer_sched
    import epu_sched_pkg::*;
#(
    parameter int unsigned NUM_ENG   = 4,
    parameter int unsigned LAYER_W   = 6,
    parameter int unsigned DESC_AW   = 8,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_start,
    input  logic [LAYER_W-1:0] cfg_num_layer,
    input  logic [DESC_AW-1:0] cfg_desc_base,
    output logic               desc_cs,
    output logic [DESC_AW-1:0] desc_addr,
    input  logic [31:0]        desc_rdata,
    output logic [NUM_ENG-1:0] eng_start,
    output logic [31:0]        eng_w8,
    input  logic [NUM_ENG-1:0] eng_finish,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LAYER_W-1:0] layer_idx
);

    sched_state_e         state;
    sched_state_e         state_next;
    logic [LAYER_W-1:0]   num_layer_q;
    logic [DESC_AW-1:0]   base_q;
    logic [ENG_ID_W-1:0]  eng_sel;
    logic [TIMEOUT_W-1:0] wd;
    logic [TIMEOUT_W-1:0] wd_inc;
    logic [NUM_ENG-1:0]   sel_onehot;
    logic [DESC_AW-1:0]   addr_w0;
    logic                 accept;
    logic                 id_bad;
    logic                 fin_sel;
    logic                 fin_other;
    logic                 wd_expire;
    logic                 last_layer;

    always_comb begin
        sel_onehot = '0;
        for (int unsigned j = 0; j < NUM_ENG; j++) begin
            sel_onehot[j] = (eng_sel == ENG_ID_W'(j));
        end
    end

    assign accept     = (state == S_IDLE) && cfg_start;
    assign addr_w0    = base_q + DESC_AW'(DESC_WORDS * layer_idx);
    assign id_bad     = 32'(eng_sel) >= NUM_ENG;
    assign fin_sel    = |(eng_finish & sel_onehot);
    assign fin_other  = |(eng_finish & ~sel_onehot);
    assign wd_inc     = wd + 1'b1;
    // Fires on the WAIT cycle in which the counter steps onto all-ones.
    assign wd_expire  = (wd_inc == '1);
    assign last_layer = (layer_idx == num_layer_q - 1'b1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        desc_cs    = 1'b0;
        desc_addr  = '0;
        eng_start  = '0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_next = (cfg_num_layer == '0) ? S_DONE : S_RD_W0;
                end
            end
            S_RD_W0: begin
                desc_cs    = 1'b1;
                desc_addr  = addr_w0;
                state_next = S_RD_W1;
            end
            S_RD_W1: begin
                desc_cs    = 1'b1;
                desc_addr  = addr_w0 + 1'b1;
                state_next = S_CAP;
            end
            S_CAP:   state_next = id_bad ? S_ERR : S_ISSUE;
            S_ISSUE: begin
                eng_start  = sel_onehot;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A stray finish from a non-selected engine outranks everything.
                if (fin_other) begin
                    state_next = S_ERR;
                end else if (fin_sel) begin
                    state_next = last_layer ? S_DONE : S_RD_W0;
                end else if (wd_expire) begin
                    state_next = S_ERR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            num_layer_q <= '0;
            base_q      <= '0;
            layer_idx   <= '0;
            eng_sel     <= '0;
            eng_w8      <= '0;
            wd          <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (accept) begin
                num_layer_q <= cfg_num_layer;
                base_q      <= cfg_desc_base;
                layer_idx   <= '0;
                err         <= 1'b0;
            end else if (state == S_ERR) begin
                err <= 1'b1;
            end
            if (state == S_RD_W1) begin
                eng_sel <= desc_rdata[ENG_ID_LSB +: ENG_ID_W];
            end
            if (state == S_CAP) begin
                eng_w8 <= desc_rdata;
            end
            if (state == S_ISSUE) begin
                wd <= '0;
            end else if (state == S_WAIT) begin
                wd <= wd_inc;
            end
            if (state == S_WAIT && state_next == S_RD_W0) begin
                layer_idx <= layer_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_epu_layer_sched.sv
// Directed bench for epu_layer_sched: instance A (4 engines, 4-bit watchdog)
// and instance B (2 engines) share one descriptor memory model.
module tb_epu_layer_sched;
    import epu_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  cfg_num_layer;
    logic [7:0]  cfg_desc_base;
    logic        cfg_start_a, cfg_start_b;

    logic        cs_a, busy_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] rdata_a, w8_a;
    logic [3:0]  start_a, finish_a;
    logic [5:0]  idx_a;

    logic        cs_b, busy_b, done_b, err_b;
    logic [7:0]  addr_b;
    logic [31:0] rdata_b, w8_b;
    logic [1:0]  start_b, finish_b;
    logic [5:0]  idx_b;

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cs_a) rdata_a <= mem[addr_a];
        if (cs_b) rdata_b <= mem[addr_b];
    end

    epu_layer_sched #(.NUM_ENG(4), .LAYER_W(6), .DESC_AW(8), .TIMEOUT_W(4)) dut_a (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start_a), .cfg_num_layer(cfg_num_layer),
        .cfg_desc_base(cfg_desc_base), .desc_cs(cs_a), .desc_addr(addr_a), .desc_rdata(rdata_a),
        .eng_start(start_a), .eng_w8(w8_a), .eng_finish(finish_a), .busy(busy_a),
        .done(done_a), .err(err_a), .layer_idx(idx_a)
    );

    epu_layer_sched #(.NUM_ENG(2), .LAYER_W(6), .DESC_AW(8), .TIMEOUT_W(20)) dut_b (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start_b), .cfg_num_layer(cfg_num_layer),
        .cfg_desc_base(cfg_desc_base), .desc_cs(cs_b), .desc_addr(addr_b), .desc_rdata(rdata_b),
        .eng_start(start_b), .eng_w8(w8_b), .eng_finish(finish_b), .busy(busy_b),
        .done(done_b), .err(err_b), .layer_idx(idx_b)
    );

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cs_a, addr_a, start_a, w8_a, busy_a, done_a, err_a, idx_a} !== '0) begin
            errors++;
            $display("FAIL reset_a got cs=%b addr=%h start=%b w8=%h busy=%b done=%b err=%b idx=%0d expected all zero",
                     cs_a, addr_a, start_a, w8_a, busy_a, done_a, err_a, idx_a);
        end
        checks++;
        if ({cs_b, addr_b, start_b, w8_b, busy_b, done_b, err_b, idx_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got cs=%b addr=%h start=%b w8=%h busy=%b done=%b err=%b idx=%0d expected all zero",
                     cs_b, addr_b, start_b, w8_b, busy_b, done_b, err_b, idx_b);
        end
        rstn = 1'b1;
    endtask

    task automatic test_three_layers();
        logic [3:0]  exp_pat [3];
        logic [31:0] exp_w8  [3];
        logic [3:0]  fin_pat;
        int nstart = 0, ndone = 0, exp_at = 4, fin_at = -1;
        exp_pat = '{4'b0001, 4'b0010, 4'b0001};
        exp_w8  = '{32'h0102_0304, 32'hA0B0_C0D0, 32'hFFFF_FFFF};
        fin_pat = '0;
        mem[8'h10] = {30'h0, ENG_CONV1X1};  mem[8'h11] = 32'h0102_0304;
        mem[8'h12] = {30'h0, ENG_CONV3X3};  mem[8'h13] = 32'hA0B0_C0D0;
        mem[8'h14] = 32'hFFFF_FFF0;         mem[8'h15] = 32'hFFFF_FFFF;
        @(negedge clk);
        cfg_num_layer = 6'd3; cfg_desc_base = 8'h10; cfg_start_a = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            cfg_start_a = 1'b0;
            finish_a    = '0;
            if (start_a !== 4'b0000) begin
                if (nstart < 3) begin
                    checks++;
                    if (t != exp_at) begin
                        errors++;
                        $display("FAIL l3_start_time[%0d] got cycle %0d expected %0d", nstart, t, exp_at);
                    end
                    checks++;
                    if (start_a !== exp_pat[nstart]) begin
                        errors++;
                        $display("FAIL l3_start_pat[%0d] got %b expected %b", nstart, start_a, exp_pat[nstart]);
                    end
                    checks++;
                    if (w8_a !== exp_w8[nstart]) begin
                        errors++;
                        $display("FAIL l3_w8[%0d] got %h expected %h", nstart, w8_a, exp_w8[nstart]);
                    end
                    fin_pat = exp_pat[nstart];
                end
                nstart++;
                fin_at = t + 10;
            end
            if (t == fin_at) begin
                finish_a = fin_pat;
                exp_at   = t + 4;
            end
            if (done_a === 1'b1) ndone++;
        end
        checks++;
        if (nstart != 3) begin errors++; $display("FAIL l3_start_count got %0d expected 3", nstart); end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL l3_done_count got %0d expected 1", ndone); end
        checks++;
        if ({err_a, busy_a} !== 2'b00) begin errors++; $display("FAIL l3_err_busy got %b expected 00", {err_a, busy_a}); end
        checks++;
        if (idx_a !== 6'd2) begin errors++; $display("FAIL l3_layer_idx got %0d expected 2", idx_a); end
    endtask

    task automatic test_zero_layers();
        int done_at = -1, ndone = 0, ncs = 0, nst = 0;
        @(negedge clk);
        cfg_num_layer = 6'd0; cfg_desc_base = 8'h70; cfg_start_a = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            cfg_start_a = 1'b0;
            if (done_a === 1'b1) begin ndone++; done_at = t; end
            if (cs_a !== 1'b0) ncs++;
            if (start_a !== 4'b0000) nst++;
        end
        checks++;
        if (done_at != 2 || ndone != 1) begin
            errors++;
            $display("FAIL zero_done got cycle %0d count %0d expected cycle 2 count 1", done_at, ndone);
        end
        checks++;
        if (ncs != 0 || nst != 0) begin
            errors++;
            $display("FAIL zero_activity got cs %0d starts %0d expected 0 0", ncs, nst);
        end
    endtask

    task automatic test_bad_id();
        int nst = 0, ndone = 0, st_at = -1;
        mem[8'h40] = 32'h0000_0006; mem[8'h41] = 32'h1111_2222;
        mem[8'h50] = {30'h0, ENG_CONV3X3}; mem[8'h51] = 32'h1234_5678;
        @(negedge clk);
        cfg_num_layer = 6'd1; cfg_desc_base = 8'h40; cfg_start_b = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            cfg_start_b = 1'b0;
            if (start_b !== 2'b00) nst++;
            if (done_b === 1'b1) ndone++;
            if (t == 5) begin
                checks++;
                if ({err_b, busy_b} !== 2'b10) begin
                    errors++;
                    $display("FAIL badid_err_busy got %b expected 10", {err_b, busy_b});
                end
            end
        end
        checks++;
        if (nst != 0 || ndone != 0) begin
            errors++;
            $display("FAIL badid_activity got starts %0d done %0d expected 0 0", nst, ndone);
        end
        ndone = 0;
        @(negedge clk);
        cfg_desc_base = 8'h50; cfg_start_b = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            cfg_start_b = 1'b0;
            finish_b    = '0;
            if (t == 1) begin
                checks++;
                if (err_b !== 1'b0) begin errors++; $display("FAIL badid_err_clear got %b expected 0", err_b); end
            end
            if (start_b !== 2'b00 && st_at < 0) begin
                st_at = t;
                checks++;
                if ({start_b, w8_b} !== {2'b10, 32'h1234_5678} || t != 4) begin
                    errors++;
                    $display("FAIL badid_good_start got %b/%h at %0d expected 10/12345678 at 4", start_b, w8_b, t);
                end
            end
            if (t == 6) finish_b = 2'b10;
            if (done_b === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 1 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL badid_good_done got done %0d err %b expected 1 0", ndone, err_b);
        end
    endtask

    task automatic test_wrong_finish();
        logic [3:0] pat;
        int ndone;
        mem[8'h20] = {30'h0, ENG_CONV3X3}; mem[8'h21] = 32'h0000_0055;
        for (int k = 0; k < 2; k++) begin
            pat   = (k == 0) ? 4'b0101 : 4'b0110;
            ndone = 0;
            @(negedge clk);
            cfg_num_layer = 6'd1; cfg_desc_base = 8'h20; cfg_start_a = 1'b1;
            for (int t = 1; t <= 12; t++) begin
                @(negedge clk);
                cfg_start_a = 1'b0;
                finish_a    = '0;
                if (t == 4) begin
                    checks++;
                    if (start_a !== 4'b0010) begin errors++; $display("FAIL wrongfin_start[%0d] got %b expected 0010", k, start_a); end
                end
                if (t == 6) finish_a = pat;
                if (t == 8) begin
                    checks++;
                    if ({err_a, busy_a} !== 2'b10) begin
                        errors++;
                        $display("FAIL wrongfin_err_busy[%0d] got %b expected 10", k, {err_a, busy_a});
                    end
                end
                if (done_a === 1'b1) ndone++;
            end
            checks++;
            if (ndone != 0) begin errors++; $display("FAIL wrongfin_done[%0d] got %0d expected 0", k, ndone); end
        end
    endtask

    task automatic test_timeout_busy_start();
        int ncs = 0, err_at = -1, ndone = 0;
        mem[8'h30] = {30'h0, ENG_POOL}; mem[8'h31] = 32'h0000_0077;
        @(negedge clk);
        cfg_num_layer = 6'd1; cfg_desc_base = 8'h30; cfg_start_a = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            cfg_start_a = 1'b0;
            if (t == 6) begin cfg_start_a = 1'b1; cfg_num_layer = 6'd5; cfg_desc_base = 8'h00; end
            if (cs_a === 1'b1) ncs++;
            if (err_a === 1'b1 && err_at < 0) err_at = t;
            if (done_a === 1'b1) ndone++;
            if (t == 20) begin
                checks++;
                if (busy_a !== 1'b1) begin errors++; $display("FAIL timeout_busy_late got %b expected 1", busy_a); end
            end
        end
        checks++;
        if (err_at != 21) begin errors++; $display("FAIL timeout_err_cycle got %0d expected 21", err_at); end
        checks++;
        if (ncs != 2) begin errors++; $display("FAIL busy_start_reads got %0d expected 2", ncs); end
        checks++;
        if (ndone != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle got done %0d busy %b expected 0 0", ndone, busy_a);
        end
    endtask

    task automatic test_reset_mid_pass();
        int ndone = 0;
        mem[8'h60] = {30'h0, ENG_FC};      mem[8'h61] = 32'hDEAD_0001;
        mem[8'h62] = {30'h0, ENG_CONV3X3}; mem[8'h63] = 32'hBEEF_0002;
        @(negedge clk);
        cfg_num_layer = 6'd2; cfg_desc_base = 8'h60; cfg_start_a = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            cfg_start_a = 1'b0;
            finish_a    = '0;
            rstn        = 1'b1;
            if (t == 1) begin
                checks++;
                if ({cs_a, addr_a} !== {1'b1, 8'h60}) begin
                    errors++;
                    $display("FAIL rst_first_read got cs=%b addr=%h expected 1/60", cs_a, addr_a);
                end
            end
            if (t == 4) begin
                checks++;
                if (start_a !== 4'b1000) begin errors++; $display("FAIL rst_start0 got %b expected 1000", start_a); end
            end
            if (t == 6) finish_a = 4'b1000;
            if (t == 10) begin
                checks++;
                if ({start_a, w8_a} !== {4'b0010, 32'hBEEF_0002}) begin
                    errors++;
                    $display("FAIL rst_start1 got %b/%h expected 0010/beef0002", start_a, w8_a);
                end
            end
            if (t == 12) begin
                checks++;
                if (idx_a !== 6'd1) begin errors++; $display("FAIL rst_idx_before got %0d expected 1", idx_a); end
                rstn = 1'b0;
            end
            if (t == 13) begin
                checks++;
                if ({cs_a, addr_a, start_a, w8_a, busy_a, done_a, err_a, idx_a} !== '0) begin
                    errors++;
                    $display("FAIL rst_outputs got cs=%b addr=%h start=%b w8=%h busy=%b done=%b err=%b idx=%0d expected all zero",
                             cs_a, addr_a, start_a, w8_a, busy_a, done_a, err_a, idx_a);
                end
            end
        end
        cfg_num_layer = 6'd1; cfg_start_a = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            cfg_start_a = 1'b0;
            finish_a    = '0;
            if (t == 4) begin
                checks++;
                if ({start_a, w8_a, idx_a} !== {4'b1000, 32'hDEAD_0001, 6'd0}) begin
                    errors++;
                    $display("FAIL rst_restart got %b/%h/%0d expected 1000/dead0001/0", start_a, w8_a, idx_a);
                end
            end
            if (t == 6) finish_a = 4'b1000;
            if (done_a === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL rst_restart_done got %0d expected 1", ndone); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rdata_a = '0; rdata_b = '0;
        cfg_start_a = 1'b0; cfg_start_b = 1'b0;
        cfg_num_layer = '0; cfg_desc_base = '0;
        finish_a = '0; finish_b = '0;
        test_reset();
        test_three_layers();
        test_zero_layers();
        test_bad_id();
        test_wrong_finish();
        test_timeout_busy_start();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
